// File: rtl/mp_fifo.sv
// Multiport synchronous FIFO: up to 8 write and 8 read ports per clock, granted in ascending port order.
// Define MP_FIFO_ATOMIC_WR_EN to make each cycle's writes all-or-nothing.
module mp_fifo #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter int WR_PORTS = 2,
  parameter int RD_PORTS = 2
) (
  input  logic                          clk,
  input  logic                          srst,
  input  logic [WR_PORTS*WIDTH-1:0]     din,
  input  logic [WR_PORTS-1:0]           wr_en,
  output logic [WR_PORTS-1:0]           wr_fail,
  input  logic [RD_PORTS-1:0]           rd_en,
  output logic [RD_PORTS-1:0]           rd_fail,
  output logic [RD_PORTS*WIDTH-1:0]     dout,
  output logic [RD_PORTS-1:0]           dout_valid,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(DEPTH+1)-1:0]    data_count,
  output logic [$clog2(DEPTH+1)-1:0]    free_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int AW = CW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head, tail;
  logic [CW-1:0]    count, free, wr_limit, a_cnt, r_cnt;

  logic [WR_PORTS-1:0] wr_acc;
  logic [PW-1:0]       wr_addr [WR_PORTS];
  logic [RD_PORTS-1:0] rd_grant;
  logic [PW-1:0]       rd_addr [RD_PORTS];

  // base + off never reaches 2*DEPTH, so one conditional subtract suffices
  function automatic logic [PW-1:0] wrap(input logic [PW-1:0] base, input logic [CW-1:0] off);
    if (AW'(base) + AW'(off) >= AW'(DEPTH))
      return PW'(AW'(base) + AW'(off) - AW'(DEPTH));
    else
      return PW'(AW'(base) + AW'(off));
  endfunction

  always_comb begin
    free = CW'(DEPTH) - count;
`ifdef MP_FIFO_ATOMIC_WR_EN
    wr_limit = (CW'($countones(wr_en)) <= free) ? free : '0;
`else
    wr_limit = free;
`endif
    a_cnt  = '0;
    wr_acc = '0;
    for (int unsigned i = 0; i < WR_PORTS; i++) begin
      wr_addr[i] = wrap(tail, a_cnt);
      if (wr_en[i] && (a_cnt < wr_limit)) begin
        wr_acc[i] = 1'b1;
        a_cnt     = a_cnt + CW'(1);
      end
    end
    r_cnt    = '0;
    rd_grant = '0;
    for (int unsigned i = 0; i < RD_PORTS; i++) begin
      rd_addr[i] = wrap(head, r_cnt);
      if (rd_en[i] && (r_cnt < count)) begin
        rd_grant[i] = 1'b1;
        r_cnt       = r_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      dout       <= '0;
      dout_valid <= '0;
      wr_fail    <= '0;
      rd_fail    <= '0;
    end else begin
      for (int unsigned i = 0; i < WR_PORTS; i++)
        if (wr_acc[i]) mem[wr_addr[i]] <= din[i*WIDTH +: WIDTH];
      for (int unsigned i = 0; i < RD_PORTS; i++)
        if (rd_grant[i]) dout[i*WIDTH +: WIDTH] <= mem[rd_addr[i]];
      dout_valid <= rd_grant;
      rd_fail    <= rd_en & ~rd_grant;
      wr_fail    <= wr_en & ~wr_acc;
      tail       <= wrap(tail, a_cnt);
      head       <= wrap(head, r_cnt);
      count      <= count + a_cnt - r_cnt;
    end
  end

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign data_count = count;
  assign free_count = free;

endmodule

// File: tb/tb_mp_fifo.sv
// Randomized bench for mp_fifo: DEPTH=16 and DEPTH=5 instances share stimulus, each checked against a queue model.
module tb_mp_fifo;

  logic        clk = 1'b0;
  logic        srst;
  logic [63:0] din;
  logic [1:0]  wr_en, rd_en;

  logic [1:0]  a_wf, a_rf, a_dv, b_wf, b_rf, b_dv;
  logic [63:0] a_dout, b_dout;
  logic        a_full, a_empty, b_full, b_empty;
  logic [4:0]  a_cnt, a_free;
  logic [2:0]  b_cnt, b_free;

  int total = 0;
  int bad   = 0;

  logic [31:0] mq [2][$];
  logic [63:0] exp_dout [2];
  logic [1:0]  exp_dv [2], exp_wf [2], exp_rf [2];

  always #5 clk = ~clk;

  mp_fifo #(.WIDTH(32), .DEPTH(16), .WR_PORTS(2), .RD_PORTS(2)) u_d16 (
    .clk(clk), .srst(srst), .din(din), .wr_en(wr_en), .wr_fail(a_wf),
    .rd_en(rd_en), .rd_fail(a_rf), .dout(a_dout), .dout_valid(a_dv),
    .full(a_full), .empty(a_empty), .data_count(a_cnt), .free_count(a_free));

  mp_fifo #(.WIDTH(32), .DEPTH(5), .WR_PORTS(2), .RD_PORTS(2)) u_d5 (
    .clk(clk), .srst(srst), .din(din), .wr_en(wr_en), .wr_fail(b_wf),
    .rd_en(rd_en), .rd_fail(b_rf), .dout(b_dout), .dout_valid(b_dv),
    .full(b_full), .empty(b_empty), .data_count(b_cnt), .free_count(b_free));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model computed from pre-edge inputs and queue contents.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int d, sz, fr, nw, a, r, acc;
      d  = (k == 0) ? 16 : 5;
      sz = mq[k].size();
      fr = d - sz;
      nw = 0; r = 0; acc = 0;
      if (srst) begin
        mq[k].delete();
        exp_dout[k] = '0; exp_dv[k] = '0; exp_wf[k] = '0; exp_rf[k] = '0;
        continue;
      end
      for (int i = 0; i < 2; i++) nw += int'(wr_en[i]);
`ifdef MP_FIFO_ATOMIC_WR_EN
      a = (nw <= fr) ? nw : 0;
`else
      a = (nw < fr) ? nw : fr;
`endif
      exp_dv[k] = '0; exp_wf[k] = '0; exp_rf[k] = '0;
      for (int i = 0; i < 2; i++)
        if (rd_en[i]) begin
          if (r < sz) begin
            exp_dout[k][i*32 +: 32] = mq[k][r];
            exp_dv[k][i] = 1'b1;
            r++;
          end else exp_rf[k][i] = 1'b1;
        end
      repeat (r) void'(mq[k].pop_front());
      for (int i = 0; i < 2; i++)
        if (wr_en[i]) begin
          if (acc < a) begin
            mq[k].push_back(din[i*32 +: 32]);
            acc++;
          end else exp_wf[k][i] = 1'b1;
        end
    end
  endtask

  task automatic check_all();
    int s0, s1;
    s0 = mq[0].size();
    s1 = mq[1].size();
    check("d16_dout",  a_dout,  exp_dout[0]);
    check("d16_valid", 64'(a_dv), 64'(exp_dv[0]));
    check("d16_wfail", 64'(a_wf), 64'(exp_wf[0]));
    check("d16_rfail", 64'(a_rf), 64'(exp_rf[0]));
    check("d16_count", 64'(a_cnt), 64'(s0));
    check("d16_free",  64'(a_free), 64'(16 - s0));
    check("d16_full",  64'(a_full), 64'(s0 == 16));
    check("d16_empty", 64'(a_empty), 64'(s0 == 0));
    check("d5_dout",   b_dout,  exp_dout[1]);
    check("d5_valid",  64'(b_dv), 64'(exp_dv[1]));
    check("d5_wfail",  64'(b_wf), 64'(exp_wf[1]));
    check("d5_rfail",  64'(b_rf), 64'(exp_rf[1]));
    check("d5_count",  64'(b_cnt), 64'(s1));
    check("d5_free",   64'(b_free), 64'(5 - s1));
    check("d5_full",   64'(b_full), 64'(s1 == 5));
    check("d5_empty",  64'(b_empty), 64'(s1 == 0));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input logic r, input logic [1:0] w, input logic [1:0] rd,
                       input logic [31:0] d1, input logic [31:0] d0);
    srst = r; wr_en = w; rd_en = rd; din = {d1, d0};
    tick();
  endtask

  task automatic do_reset();
    drive(1'b1, 2'b00, 2'b00, '0, '0);
    srst = 1'b0;
  endtask

  initial begin
    srst = 1'b1; wr_en = '0; rd_en = '0; din = '0;
    do_reset();
    drive(1'b0, 2'b00, 2'b00, '0, '0);
    check("rst_free16", 64'(a_free), 64'd16);
    check("rst_empty",  64'(a_empty), 64'd1);

    // Ordering across ports
    do_reset();
    drive(1'b0, 2'b10, 2'b00, 32'hA, 32'h0);
    drive(1'b0, 2'b11, 2'b00, 32'hC, 32'hB);
    drive(1'b0, 2'b00, 2'b11, '0, '0);
    check("ord_first", a_dout, {32'hB, 32'hA});
    drive(1'b0, 2'b00, 2'b10, '0, '0);
    check("ord_second", 64'(a_dout[63:32]), 64'hC);
    check("ord_valid",  64'(a_dv), 64'b10);

    // Overflow on DEPTH=5 with count=4
    do_reset();
    drive(1'b0, 2'b11, 2'b00, 32'h11, 32'h10);
    drive(1'b0, 2'b11, 2'b00, 32'h13, 32'h12);
    drive(1'b0, 2'b11, 2'b00, 32'h15, 32'h14);
`ifdef MP_FIFO_ATOMIC_WR_EN
    check("ovf_wfail", 64'(b_wf), 64'b11);
    check("ovf_count", 64'(b_cnt), 64'd4);
`else
    check("ovf_wfail", 64'(b_wf), 64'b10);
    check("ovf_full",  64'(b_full), 64'd1);
`endif

    // Underflow with count=1, then again with a concurrent write
    do_reset();
    drive(1'b0, 2'b01, 2'b00, '0, 32'h21);
    drive(1'b0, 2'b00, 2'b11, '0, '0);
    check("udf_valid", 64'(b_dv), 64'b01);
    check("udf_rfail", 64'(b_rf), 64'b10);
    check("udf_empty", 64'(b_empty), 64'd1);
    drive(1'b0, 2'b01, 2'b00, '0, 32'h22);
    drive(1'b0, 2'b01, 2'b11, '0, 32'h23);
    check("udfw_valid", 64'(b_dv), 64'b01);
    check("udfw_data",  64'(b_dout[31:0]), 64'h22);

    // Wrap on DEPTH=5, steady two-in/two-out
    do_reset();
    drive(1'b0, 2'b11, 2'b00, 32'h101, 32'h100);
    for (int c = 0; c < 12; c++) begin
      drive(1'b0, 2'b11, 2'b11, 32'h200 + 32'(2*c+1), 32'h200 + 32'(2*c));
      check("wrap_count", 64'(b_cnt), 64'd2);
    end
    drive(1'b1, 2'b11, 2'b11, 32'h3, 32'h2);
    srst = 1'b0;
    check("mid_rst_count", 64'(b_cnt), 64'd0);
    drive(1'b0, 2'b00, 2'b01, '0, '0);
    check("post_rst_rfail", 64'(b_rf), 64'b01);

    // Random traffic
    for (int c = 0; c < 400; c++)
      drive(($urandom_range(0, 39) == 0), 2'($urandom), 2'($urandom), $urandom, $urandom);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mp_fifo.md
# mp_fifo

Multiport synchronous FIFO with up to 8 write ports and 8 read ports, each serviced in one clock. It replaces single-port FIFOs wherever a superscalar producer or consumer must push or pop several words per cycle. Ports are granted strictly in ascending index order. Requests beyond capacity are flagged per port rather than silently dropped.

## Interface
Parameters:
- WIDTH, 32, data word width in bits
- DEPTH, 16, storage entries; any integer ≥ 2 (power of two not required)
- WR_PORTS, 2, write ports, 1..8, ≤ DEPTH
- RD_PORTS, 2, read ports, 1..8, ≤ DEPTH

Ports:
- clk  in  1  clock; all logic is rising-edge
- srst  in  1  synchronous reset, active-high
- din  in  WR_PORTS*WIDTH  write data; port i occupies bits [i*WIDTH +: WIDTH]
- wr_en  in  WR_PORTS  per-port write request
- wr_fail  out  WR_PORTS  registered; port's write was not accepted
- rd_en  in  RD_PORTS  per-port read request
- rd_fail  out  RD_PORTS  registered; port's read was not granted
- dout  out  RD_PORTS*WIDTH  registered read data, same packing as din
- dout_valid  out  RD_PORTS  registered; the matching dout slice holds granted data
- full  out  1  data_count == DEPTH
- empty  out  1  data_count == 0
- data_count  out  $clog2(DEPTH+1)  stored entries
- free_count  out  $clog2(DEPTH+1)  DEPTH − data_count

## Operation
- State: head and tail pointers (0..DEPTH−1) and a count register. full, empty and free_count derive combinationally from count.
- Write grant: nw = popcount(wr_en). Accept A = min(nw, free_count sampled at the start of the cycle). The first A requesting ports, lowest index first, are accepted. They write to tail, tail+1, … in port order. All other requesting ports raise wr_fail.
- Read grant: nr = popcount(rd_en). Grant R = min(nr, data_count sampled at the start of the cycle). The first R requesting ports, lowest index first, receive head, head+1, … in port order. All other requesting ports raise rd_fail.
- Reads never see words written in the same cycle (no bypass). Writes never use space freed by same-cycle reads.
- Update: count ← count + A − R. tail ← (tail + A) mod DEPTH. head ← (head + R) mod DEPTH.
- Wrap-around uses an explicit compare-and-subtract against DEPTH. Every per-port address wraps independently.
- Non-requesting ports: fail = 0, dout_valid = 0, dout slice holds its previous value.
- Storage: flat register array. Non-power-of-two DEPTH is legal.

## Timing
- Reset values after any cycle with srst = 1:
  - count, head, tail = 0
  - empty = 1, full = 0, free_count = DEPTH
  - dout = 0, dout_valid = 0, wr_fail = 0, rd_fail = 0
- srst has priority over all requests in the same cycle. Mid-operation reset discards all contents, and no grants occur that cycle.
- Write latency: a word accepted at edge N is readable by a request sampled at edge N+1.
- Read latency: 1 cycle. A request sampled at edge N gives dout/dout_valid/rd_fail valid after edge N.
- wr_fail is valid after the edge that sampled the request.
- Flags are single-cycle pulses per request. There is no stall or retry; the producer re-presents any failed word.
- data_count, full, empty and free_count reflect post-edge state.

## Configuration
- MP_FIFO_ATOMIC_WR_EN defined: writes are all-or-nothing.
  - If nw > free_count, A = 0 and every requesting write port raises wr_fail.
  - Otherwise all requesting ports are accepted.
- Undefined (default): partial acceptance as described in Operation.
- Reads are unaffected by the macro.

## Test plan
- Reset then idle: after srst, empty = 1, data_count = 0, free_count = 16, all dout_valid, wr_fail and rd_fail = 0.
- Ordering across ports (WR_PORTS = RD_PORTS = 2): write 0xA on port 1 only, then 0xB on port 0 plus 0xC on port 1. Read with rd_en = 2'b11, then 2'b10. Required response: port0 = 0xA, port1 = 0xB, then port1 = 0xC.
- Overflow, partial mode (DEPTH = 5, count = 4): wr_en = 2'b11. Required response: port 0 accepted, wr_fail = 2'b10, full = 1.
- Same overflow with MP_FIFO_ATOMIC_WR_EN: wr_fail = 2'b11, count stays 4.
- Underflow (count = 1): rd_en = 2'b11. Required response: dout_valid = 2'b01, rd_fail = 2'b10, empty = 1 next cycle. A simultaneous write is not visible in that cycle.
- Wrap with DEPTH = 5: push/pop 2 words per cycle for 12 cycles. Required response: data stays in sequence, count stays constant. Then assert srst mid-stream: count = 0 and the next read fails.
